// File: rtl/eth_phy_10g_rx_reset_ctrl_if.sv
// Handshake bundle between the 10G RX reset sequencer and its environment
// (serdes RX, PCS/watchdog, software control).
//   reset_req        watchdog single-cycle reset request
//   force_reset      software reset, also the only exit from FAULT
//   serdes_rx_ready  serdes RX PMA/CDR ready
//   rx_block_lock    PCS block lock
//   rx_status        watchdog link-good status
//   serdes_rx_reset  serdes RX reset, active-high
//   pcs_rx_reset     PCS/watchdog reset, active-high
//   link_up          RUN with rx_status high
//   fault            retry budget exhausted
//   reset_count      saturating count of reset entries
//   state            current sequencer state code
interface eth_phy_10g_rx_reset_ctrl_if;
  logic        reset_req;
  logic        force_reset;
  logic        serdes_rx_ready;
  logic        rx_block_lock;
  logic        rx_status;
  logic        serdes_rx_reset;
  logic        pcs_rx_reset;
  logic        link_up;
  logic        fault;
  logic [15:0] reset_count;
  logic [2:0]  state;

  // Sequencer side
  modport master (
    input  reset_req, force_reset, serdes_rx_ready, rx_block_lock, rx_status,
    output serdes_rx_reset, pcs_rx_reset, link_up, fault, reset_count, state
  );

  // Environment side
  modport slave (
    output reset_req, force_reset, serdes_rx_ready, rx_block_lock, rx_status,
    input  serdes_rx_reset, pcs_rx_reset, link_up, fault, reset_count, state
  );
endinterface

// File: rtl/eth_phy_10g_rx_reset_ctrl.sv
// Reset sequencer for the 10G PHY receive path. Walks the serdes RX reset and
// PCS reset through RESET -> WAIT_READY -> WAIT_LOCK -> RUN, retries timed-out
// bring-ups up to MAX_RETRY times, then parks in FAULT until force_reset.
// Ports:
//   clk    serdes RX parallel clock
//   rst_n  asynchronous active-low reset
//   ctrl   eth_phy_10g_rx_reset_ctrl_if.master (requests in, resets/status out)
// All outputs are registered and decoded from the next state.
module eth_phy_10g_rx_reset_ctrl #(
  parameter int unsigned RESET_CYCLES  = 64,
  parameter int unsigned READY_TIMEOUT = 65536,
  parameter int unsigned LOCK_TIMEOUT  = 131072,
  parameter int unsigned MAX_RETRY     = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  eth_phy_10g_rx_reset_ctrl_if.master   ctrl
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;
  localparam int unsigned MAX_AB  = (READY_TIMEOUT > LOCK_TIMEOUT) ? READY_TIMEOUT : LOCK_TIMEOUT;
  localparam int unsigned TMR_MAX = (RESET_CYCLES > MAX_AB) ? RESET_CYCLES : MAX_AB;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  // Timer holds "cycles left minus one"; the state is left when it reads zero.
  localparam logic [TMR_W-1:0] RESET_LOAD = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] READY_LOAD = TMR_W'(READY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCK_TIMEOUT - 1);
  // After rst_n the first clock edge only opens the RESET window, so one extra count.
  localparam logic [TMR_W-1:0] POR_LOAD   = TMR_W'(RESET_CYCLES);

  localparam logic [CNT_W-1:0]   CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               enter_reset;
  logic               timeout;

  logic serdes_rst_q, serdes_rst_d;
  logic pcs_rst_q,    pcs_rst_d;
  logic link_q,       link_d;
  logic fault_q,      fault_d;

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET;
      timer_q      <= POR_LOAD;
      retry_q      <= '0;
      count_q      <= '0;
      serdes_rst_q <= 1'b1;
      pcs_rst_q    <= 1'b1;
      link_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      count_q      <= count_d;
      serdes_rst_q <= serdes_rst_d;
      pcs_rst_q    <= pcs_rst_d;
      link_q       <= link_d;
      fault_q      <= fault_d;
    end
  end

  // Next state, counter updates and next-state output decode
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    enter_reset = 1'b0;
    timeout     = 1'b0;
    timer_d     = (timer_q != '0) ? timer_q - TMR_W'(1) : timer_q;

    if (ctrl.force_reset) begin
      state_d     = ST_RESET;
      retry_d     = '0;
      enter_reset = 1'b1;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          if (timer_q == '0) state_d = ST_WAIT_READY;
        end
        ST_WAIT_READY: begin
          if (ctrl.serdes_rx_ready) state_d = ST_WAIT_LOCK;
          else if (timer_q == '0)   timeout = 1'b1;
        end
        ST_WAIT_LOCK: begin
          // Losing the serdes is a plain restart, not a failed attempt.
          if (!ctrl.serdes_rx_ready) begin
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end else if (ctrl.rx_block_lock) begin
            state_d = ST_RUN;
          end else if (timer_q == '0) begin
            timeout = 1'b1;
          end
        end
        ST_RUN: begin
          if (ctrl.rx_status) retry_d = '0;
          if (ctrl.reset_req || !ctrl.serdes_rx_ready) begin
            state_d     = ST_RESET;
            enter_reset = 1'b1;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RESET;
        end
      endcase
    end

    if (timeout) begin
      if (retry_q < RETRY_MAX) begin
        retry_d     = retry_q + RETRY_W'(1);
        state_d     = ST_RESET;
        enter_reset = 1'b1;
      end else begin
        state_d = ST_FAULT;
      end
    end

    // Timer reloads on every state entry, including a RESET restart.
    if (enter_reset) begin
      timer_d = RESET_LOAD;
    end else if (state_d != state_q) begin
      unique case (state_d)
        ST_WAIT_READY: timer_d = READY_LOAD;
        ST_WAIT_LOCK:  timer_d = LOCK_LOAD;
        default:       timer_d = '0;
      endcase
    end

    count_d = (enter_reset && (count_q != CNT_SAT)) ? count_q + CNT_W'(1) : count_q;

    serdes_rst_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
    pcs_rst_d    = (state_d != ST_WAIT_LOCK) && (state_d != ST_RUN);
    fault_d      = (state_d == ST_FAULT);
    link_d       = (state_d == ST_RUN) && ctrl.rx_status;
  end

  assign ctrl.serdes_rx_reset = serdes_rst_q;
  assign ctrl.pcs_rx_reset    = pcs_rst_q;
  assign ctrl.link_up         = link_q;
  assign ctrl.fault           = fault_q;
  assign ctrl.reset_count     = count_q;
  assign ctrl.state           = state_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_reset_ctrl.sv
// Bench for eth_phy_10g_rx_reset_ctrl: directed bring-up scenarios plus sticky
// random stimulus, checked every cycle against a cycles-in-state reference model.
module tb_eth_phy_10g_rx_reset_ctrl;

  localparam int unsigned RESET_CYCLES  = 4;
  localparam int unsigned READY_TIMEOUT = 10;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned MAX_RETRY     = 2;

  localparam int S_RESET = 0, S_WR = 1, S_WL = 2, S_RUN = 3, S_FAULT = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  eth_phy_10g_rx_reset_ctrl_if bus ();

  eth_phy_10g_rx_reset_ctrl #(
    .RESET_CYCLES (RESET_CYCLES),
    .READY_TIMEOUT(READY_TIMEOUT),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ctrl (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: state, cycles completed in state, retries, entries, link.
  int m_state;
  int m_age;
  int m_retry;
  int m_count;
  bit m_link;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_RESET;
    m_age   = -1;   // first edge after release opens the RESET window
    m_retry = 0;
    m_count = 0;
    m_link  = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_edge();
    int  nxt;
    int  in_state;
    bit  enter;
    bit  tmo;
    nxt      = m_state;
    enter    = 1'b0;
    tmo      = 1'b0;
    in_state = m_age + 1;
    if (bus.force_reset) begin
      nxt     = S_RESET;
      m_retry = 0;
      enter   = 1'b1;
    end else begin
      case (m_state)
        S_RESET: if (in_state >= int'(RESET_CYCLES)) nxt = S_WR;
        S_WR: begin
          if (bus.serdes_rx_ready) nxt = S_WL;
          else if (in_state >= int'(READY_TIMEOUT)) tmo = 1'b1;
        end
        S_WL: begin
          if (!bus.serdes_rx_ready) begin nxt = S_RESET; enter = 1'b1; end
          else if (bus.rx_block_lock) nxt = S_RUN;
          else if (in_state >= int'(LOCK_TIMEOUT)) tmo = 1'b1;
        end
        S_RUN: begin
          if (bus.rx_status) m_retry = 0;
          if (bus.reset_req || !bus.serdes_rx_ready) begin nxt = S_RESET; enter = 1'b1; end
        end
        default: nxt = m_state;
      endcase
    end
    if (tmo) begin
      if (m_retry < int'(MAX_RETRY)) begin
        m_retry++;
        nxt   = S_RESET;
        enter = 1'b1;
      end else begin
        nxt = S_FAULT;
      end
    end
    if (enter && m_count < 65535) m_count++;
    if (enter || nxt != m_state) m_age = 0;
    else                         m_age++;
    m_state = nxt;
    m_link  = (nxt == S_RUN) && bus.rx_status;
  endtask

  task automatic check_all();
    check("state",           32'(bus.state),           32'(m_state));
    check("serdes_rx_reset", 32'(bus.serdes_rx_reset), 32'(m_state == S_RESET || m_state == S_FAULT));
    check("pcs_rx_reset",    32'(bus.pcs_rx_reset),    32'(m_state != S_WL && m_state != S_RUN));
    check("fault",           32'(bus.fault),           32'(m_state == S_FAULT));
    check("link_up",         32'(bus.link_up),         32'(m_link));
    check("reset_count",     32'(bus.reset_count),     32'(m_count));
  endtask

  // Advance one clock: model follows the edge, DUT is sampled on the falling edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_in(input logic req, input logic frc, input logic rdy,
                        input logic lck, input logic sts);
    bus.reset_req       = req;
    bus.force_reset     = frc;
    bus.serdes_rx_ready = rdy;
    bus.rx_block_lock   = lck;
    bus.rx_status       = sts;
  endtask

  // Called at a falling edge; holds reset two cycles and releases away from clk.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);

    // Bring-up
    do_reset();
    for (int k = 0; k < 30; k++) begin
      set_in(0, 0, k >= 6, k >= 10, k >= 15);
      step();
    end
    check("bringup_state", 32'(bus.state), 32'(S_RUN));
    check("bringup_link", 32'(bus.link_up), 32'd1);
    check("bringup_count", 32'(bus.reset_count), 32'd0);

    // Watchdog request
    set_in(1, 0, 1, 1, 1);
    step();
    check("wd_enter_reset", 32'(bus.state), 32'(S_RESET));
    check("wd_link_down", 32'(bus.link_up), 32'd0);
    set_in(0, 0, 1, 1, 1);
    step(3);
    check("wd_reset_4th", 32'(bus.serdes_rx_reset), 32'd1);
    step();
    check("wd_reset_released", 32'(bus.serdes_rx_reset), 32'd0);
    step(8);
    check("wd_run", 32'(bus.state), 32'(S_RUN));
    check("wd_count", 32'(bus.reset_count), 32'd1);

    // Retry exhaustion
    set_in(0, 0, 0, 0, 0);
    do_reset();
    step(3 * (int'(RESET_CYCLES) + int'(READY_TIMEOUT)));
    check("retry_pre_fault", 32'(bus.state), 32'(S_WR));
    step();
    check("retry_fault_state", 32'(bus.state), 32'(S_FAULT));
    check("retry_fault_flag", 32'(bus.fault), 32'd1);
    check("retry_count", 32'(bus.reset_count), 32'd2);
    set_in(1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0);
    step(5);
    check("fault_ignores_req", 32'(bus.state), 32'(S_FAULT));
    check("fault_serdes_rst", 32'(bus.serdes_rx_reset), 32'd1);

    // Fault recovery
    set_in(0, 1, 1, 1, 1);
    step();
    check("recover_fault_clr", 32'(bus.fault), 32'd0);
    set_in(0, 0, 1, 1, 1);
    step(10);
    check("recover_run", 32'(bus.state), 32'(S_RUN));
    check("recover_count", 32'(bus.reset_count), 32'd3);

    // Restart mid-RESET with simultaneous reset_req
    set_in(1, 0, 1, 1, 1);
    step();
    set_in(0, 0, 1, 1, 1);
    step();
    set_in(1, 1, 1, 1, 1);
    step();
    check("restart_count", 32'(bus.reset_count), 32'd5);
    set_in(0, 0, 1, 1, 1);
    step(3);
    check("restart_full_len", 32'(bus.state), 32'(S_RESET));
    step();
    check("restart_exit", 32'(bus.state), 32'(S_WR));

    // Lock timeout
    set_in(0, 1, 1, 0, 0);
    step();
    set_in(0, 0, 1, 0, 0);
    step(5);
    check("lock_wait_entry", 32'(bus.state), 32'(S_WL));
    step(int'(LOCK_TIMEOUT) - 1);
    check("lock_wait_last", 32'(bus.state), 32'(S_WL));
    step();
    check("lock_timeout", 32'(bus.state), 32'(S_RESET));

    // Ready drop in RUN
    set_in(0, 0, 1, 1, 1);
    step(10);
    check("drop_pre_run", 32'(bus.state), 32'(S_RUN));
    set_in(0, 0, 0, 1, 1);
    step();
    check("drop_reset", 32'(bus.state), 32'(S_RESET));
    check("drop_link", 32'(bus.link_up), 32'd0);

    // Sticky random stimulus
    set_in(0, 0, 1, 1, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.serdes_rx_ready = ~bus.serdes_rx_ready;
      if ($urandom_range(0, 19) == 0) bus.rx_block_lock   = ~bus.rx_block_lock;
      if ($urandom_range(0, 14) == 0) bus.rx_status       = ~bus.rx_status;
      bus.reset_req   = ($urandom_range(0, 49) == 0);
      bus.force_reset = ($urandom_range(0, 299) == 0);
      step();
    end

    // Asynchronous reset mid-sequence
    set_in(0, 1, 1, 1, 1);
    step();
    set_in(0, 0, 1, 1, 1);
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("async_count_zero", 32'(bus.reset_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(12);
    check("async_rerun", 32'(bus.state), 32'(S_RUN));

    // Saturation via back-to-back forced entries
    set_in(0, 1, 1, 1, 1);
    step(65540);
    check("sat_count", 32'(bus.reset_count), 32'hFFFF);
    step(2);
    check("sat_hold", 32'(bus.reset_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
